// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// seq_pattern_tx : framed MSB-first serial pattern transmitter (1101 source)
// Revision: 1.0
// ============================================================================
module seq_pattern_tx #(
  parameter int               WIDTH           = 4,
  parameter logic [WIDTH-1:0] DEFAULT_PATTERN = 4'b1101,
  parameter logic             IDLE_LEVEL      = 1'b0,
  parameter int               CNT_W           = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             start,
  input  logic [CNT_W-1:0] frames,
  input  logic [CNT_W-1:0] gap,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] pattern_q,   pattern_d;
  logic [WIDTH-1:0] frame_pat_q, frame_pat_d;
  logic [WIDTH-1:0] shreg_q,     shreg_d;
  logic [BW-1:0]    bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] gap_q,       gap_d;
  logic [CNT_W-1:0] gap_cnt_q,   gap_cnt_d;
  logic             dout_q,      dout_d;
  logic             valid_q,     valid_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    frame_pat_d = frame_pat_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    dout_d      = IDLE_LEVEL;
    valid_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load) pattern_d = pattern_in;
        // The run uses the pre-load pattern, so it is snapshotted for reloads.
        if (start && !abort) begin
          frame_pat_d = pattern_q;
          frame_cnt_d = (frames == '0) ? CNT_ONE : frames;
          gap_d       = gap;
          shreg_d     = {pattern_q[WIDTH-2:0], 1'b0};
          bit_cnt_d   = '0;
          dout_d      = pattern_q[WIDTH-1];
          valid_d     = 1'b1;
          busy_d      = 1'b1;
          state_d     = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bit_cnt_q != LAST_BIT) begin
          dout_d    = shreg_q[WIDTH-1];
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end else begin
          frame_cnt_d = frame_cnt_q - 1'b1;
          if (frame_cnt_q != CNT_ONE) begin
            busy_d = 1'b1;
            if (gap_q != '0) begin
              gap_cnt_d = gap_q;
              state_d   = ST_GAP;
            end else begin
              shreg_d   = {frame_pat_q[WIDTH-2:0], 1'b0};
              bit_cnt_d = '0;
              dout_d    = frame_pat_q[WIDTH-1];
              valid_d   = 1'b1;
            end
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q == CNT_ONE) begin
          gap_cnt_d = '0;
          shreg_d   = {frame_pat_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = '0;
          dout_d    = frame_pat_q[WIDTH-1];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
          busy_d    = 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      pattern_q   <= DEFAULT_PATTERN;
      frame_pat_q <= DEFAULT_PATTERN;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      dout_q      <= IDLE_LEVEL;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      frame_pat_q <= frame_pat_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// tb_seq_pattern_tx : directed self-checking bench for seq_pattern_tx
// Revision: 1.0
// ============================================================================
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       clr;
  logic       load;
  logic [3:0] pattern_in;
  logic       start;
  logic [3:0] frames;
  logic [3:0] gap;
  logic       abort;
  logic       dout;
  logic       dout_valid;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] hist;
  int det_cnt;

  seq_pattern_tx dut (
    .clk        (clk),
    .clr        (clr),
    .load       (load),
    .pattern_in (pattern_in),
    .start      (start),
    .frames     (frames),
    .gap        (gap),
    .abort      (abort),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one output cycle, feed the reference 1101 detector, advance a clock.
  task automatic step(input string tag, input logic e_dout, input logic e_valid,
                      input logic e_busy, input logic e_done);
    chk({tag, ".dout"},  32'(dout),       32'(e_dout));
    chk({tag, ".valid"}, 32'(dout_valid), 32'(e_valid));
    chk({tag, ".busy"},  32'(busy),       32'(e_busy));
    chk({tag, ".done"},  32'(done),       32'(e_done));
    hist = {hist[2:0], dout};
    if (hist == 4'b1101) det_cnt++;
    tick();
  endtask

  task automatic frame(input string tag, input logic [3:0] pat);
    for (int i = 3; i >= 0; i--) step(tag, pat[i], 1'b1, 1'b1, 1'b0);
  endtask

  task automatic det_reset();
    hist    = 4'b0000;
    det_cnt = 0;
  endtask

  initial begin
    clr = 1'b1; load = 1'b0; pattern_in = 4'h0; start = 1'b0;
    frames = 4'd0; gap = 4'd0; abort = 1'b0;
    det_reset();
    tick(); tick();
    chk("rst.dout",  32'(dout),       32'd0);
    chk("rst.valid", 32'(dout_valid), 32'd0);
    chk("rst.busy",  32'(busy),       32'd0);
    chk("rst.done",  32'(done),       32'd0);
    clr = 1'b0;
    tick();

    // single frame of the default pattern
    start = 1'b1; frames = 4'd1; gap = 4'd0;
    tick();
    start = 1'b0; det_reset();
    frame("s1", 4'b1101);
    step("s1.end", 1'b0, 1'b0, 1'b0, 1'b1);
    step("s1.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s1.det", 32'(det_cnt), 32'd1);

    // loaded 1011, two frames with a two-cycle gap
    load = 1'b1; pattern_in = 4'b1011;
    tick();
    load = 1'b0; start = 1'b1; frames = 4'd2; gap = 4'd2;
    tick();
    start = 1'b0; det_reset();
    frame("s2.f0", 4'b1011);
    step("s2.gap", 1'b0, 1'b0, 1'b1, 1'b0);
    step("s2.gap", 1'b0, 1'b0, 1'b1, 1'b0);
    frame("s2.f1", 4'b1011);
    step("s2.end", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s2.det", 32'(det_cnt), 32'd0);

    // back to 1101, three contiguous frames
    load = 1'b1; pattern_in = 4'b1101;
    tick();
    load = 1'b0; start = 1'b1; frames = 4'd3; gap = 4'd0;
    tick();
    start = 1'b0; det_reset();
    frame("s3.f0", 4'b1101);
    frame("s3.f1", 4'b1101);
    frame("s3.f2", 4'b1101);
    step("s3.end", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s3.det", 32'(det_cnt), 32'd3);

    // frames=0 behaves as one frame
    start = 1'b1; frames = 4'd0; gap = 4'd5;
    tick();
    start = 1'b0;
    frame("s4", 4'b1101);
    step("s4.end", 1'b0, 1'b0, 1'b0, 1'b1);
    step("s4.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // abort on the second bit, no done pulse afterwards
    start = 1'b1; frames = 4'd2; gap = 4'd0;
    tick();
    start = 1'b0;
    step("s5.b3", 1'b1, 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    step("s5.b2", 1'b1, 1'b1, 1'b1, 1'b0);
    abort = 1'b0;
    for (int i = 0; i < 8; i++) step("s5.quiet", 1'b0, 1'b0, 1'b0, 1'b0);
    abort = 1'b1; start = 1'b1; frames = 4'd1;
    step("s5.pre", 1'b0, 1'b0, 1'b0, 1'b0);
    abort = 1'b0; start = 1'b0;
    step("s5.abst", 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    frame("s5.re", 4'b1101);
    step("s5.end", 1'b0, 1'b0, 1'b0, 1'b1);

    // load+start together: old pattern sent, new one used next time
    load = 1'b1; pattern_in = 4'b0111; start = 1'b1; frames = 4'd1; gap = 4'd0;
    tick();
    load = 1'b0; start = 1'b0;
    frame("s6.old", 4'b1101);
    step("s6.end", 1'b0, 1'b0, 1'b0, 1'b1);
    step("s6.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    load = 1'b1; pattern_in = 4'b0000; start = 1'b1; frames = 4'd9; gap = 4'd7;
    frame("s6.new", 4'b0111);
    load = 1'b0; start = 1'b0;
    step("s6.end2", 1'b0, 1'b0, 1'b0, 1'b1);
    step("s6.idle2", 1'b0, 1'b0, 1'b0, 1'b0);

    // clr in the middle of a gap
    start = 1'b1; frames = 4'd2; gap = 4'd3;
    tick();
    start = 1'b0;
    frame("s7.f0", 4'b0111);
    step("s7.gap", 1'b0, 1'b0, 1'b1, 1'b0);
    clr = 1'b1;
    #1;
    chk("s7.clr.dout",  32'(dout),       32'd0);
    chk("s7.clr.valid", 32'(dout_valid), 32'd0);
    chk("s7.clr.busy",  32'(busy),       32'd0);
    chk("s7.clr.done",  32'(done),       32'd0);
    tick();
    clr = 1'b0;
    tick();
    start = 1'b1; frames = 4'd1; gap = 4'd0;
    tick();
    start = 1'b0;
    frame("s7.dflt", 4'b1101);
    step("s7.end", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
